// File: rtl/basic_search_scheduler.sv
// Sequencer for one basic-layer integer search: loads the current block, staggers
// reference/PE preparation, tags SAD tree outputs with their position and signals done.
module basic_search_scheduler #(
    parameter int unsigned CURR_BEATS  = 16,
    parameter int unsigned REF_PRELOAD = 8,
    parameter int unsigned SEARCH_COLS = 32,
    parameter int unsigned SEARCH_ROWS = 64,
    parameter int unsigned SAD_LAT     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         curr_valid,
    input  logic [511:0] curr_data,
    output logic         curr_ready,
    output logic [511:0] current_64pixels,
    output logic         ref_begin_prepare,
    output logic         pe_begin_prepare,
    input  logic [4:0]   search_column_count,
    input  logic [6:0]   search_row_count,
    output logic         sad_valid,
    output logic [4:0]   sad_col,
    output logic [6:0]   sad_row,
    output logic         busy,
    output logic         done
);

    localparam logic [4:0] BeatLast  = 5'(CURR_BEATS - 1);
    localparam logic [7:0] PreLast   = 8'(REF_PRELOAD);
    localparam logic [4:0] ColLast   = 5'(SEARCH_COLS - 1);
    localparam logic [6:0] RowLast   = 7'(SEARCH_ROWS - 1);
    localparam logic [3:0] DrainLast = 4'(SAD_LAT - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StPreload, StSearch, StDrain} state_e;

    state_e     state_q;
    logic [4:0] beat_cnt_q;
    logic [7:0] pre_cnt_q;
    logic [3:0] drain_cnt_q;

    logic       kill;
    logic       push_valid;
    logic [4:0] push_col;
    logic [6:0] push_row;

    logic       pipe_valid_q [SAD_LAT];
    logic [4:0] pipe_col_q   [SAD_LAT];
    logic [6:0] pipe_row_q   [SAD_LAT];

    assign kill = abort && (state_q != StIdle);

    always_comb begin
        push_valid = (state_q == StSearch);
        push_col   = push_valid ? search_column_count : '0;
        push_row   = push_valid ? search_row_count : '0;
    end

    // Position tags travel alongside the SAD tree so each result leaves with its origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SAD_LAT); i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_col_q[i]   <= '0;
                pipe_row_q[i]   <= '0;
            end
        end else if (kill) begin
            for (int i = 0; i < int'(SAD_LAT); i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_col_q[i]   <= '0;
                pipe_row_q[i]   <= '0;
            end
        end else begin
            pipe_valid_q[0] <= push_valid;
            pipe_col_q[0]   <= push_col;
            pipe_row_q[0]   <= push_row;
            for (int i = 1; i < int'(SAD_LAT); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_col_q[i]   <= pipe_col_q[i-1];
                pipe_row_q[i]   <= pipe_row_q[i-1];
            end
        end
    end

    assign sad_valid = pipe_valid_q[SAD_LAT-1];
    assign sad_col   = pipe_col_q[SAD_LAT-1];
    assign sad_row   = pipe_row_q[SAD_LAT-1];
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            beat_cnt_q        <= '0;
            pre_cnt_q         <= '0;
            drain_cnt_q       <= '0;
            curr_ready        <= 1'b0;
            current_64pixels  <= '0;
            ref_begin_prepare <= 1'b0;
            pe_begin_prepare  <= 1'b0;
            done              <= 1'b0;
        end else begin
            ref_begin_prepare <= 1'b0;
            pe_begin_prepare  <= 1'b0;
            done              <= 1'b0;
            if (kill) begin
                state_q    <= StIdle;
                curr_ready <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            state_q    <= StLoad;
                            beat_cnt_q <= '0;
                            curr_ready <= 1'b1;
                        end
                    end
                    StLoad: begin
                        if (curr_valid && curr_ready) begin
                            current_64pixels <= curr_data;
                            beat_cnt_q       <= beat_cnt_q + 5'd1;
                            if (beat_cnt_q == BeatLast) begin
                                curr_ready        <= 1'b0;
                                state_q           <= StPreload;
                                ref_begin_prepare <= 1'b1;
                                pre_cnt_q         <= 8'd1;
                            end
                        end
                    end
                    StPreload: begin
                        if (pre_cnt_q == PreLast) begin
                            state_q          <= StSearch;
                            pe_begin_prepare <= 1'b1;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 8'd1;
                        end
                    end
                    StSearch: begin
                        // pe_begin_prepare is high only in the first SEARCH cycle, whose counts
                        // are stale and must not end the search.
                        if (!pe_begin_prepare && search_column_count == ColLast &&
                            search_row_count == RowLast) begin
                            state_q     <= StDrain;
                            drain_cnt_q <= '0;
                        end
                    end
                    StDrain: begin
                        if (done) begin
                            state_q <= StIdle;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 4'd1;
                            if (drain_cnt_q == DrainLast) begin
                                done <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_basic_search_scheduler.sv
// Scoreboard bench: stimulus predicts accept/ref/pe/done/SAD-tag events by cycle,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_basic_search_scheduler;

    localparam int BEATS = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         sel = 1'b0;
    logic         curr_valid = 1'b0;
    logic [511:0] curr_data = '0;
    logic [4:0]   col_in = '0;
    logic [6:0]   row_in = '0;

    logic         a_ready, a_ref, a_pe, a_sv, a_busy, a_done;
    logic [511:0] a_px;
    logic [4:0]   a_col;
    logic [6:0]   a_row;
    logic         b_ready, b_ref, b_pe, b_sv, b_busy, b_done;
    logic [511:0] b_px;
    logic [4:0]   b_col;
    logic [6:0]   b_row;

    logic         m_ready, m_ref, m_pe, m_sv, m_busy, m_done;
    logic [511:0] m_px;
    logic [4:0]   m_col;
    logic [6:0]   m_row;

    int lat = 4, pre = 8, cols = 32, rows = 64;
    int cyc = 0;
    int errors = 0, checks = 0;

    typedef struct {int cyc; logic [4:0] col; logic [6:0] row;} sad_t;
    typedef struct {int cyc; int kind;} evt_t;  // kind: 0 accept, 1 ref, 2 pe, 3 done
    sad_t sad_q[$];
    evt_t evt_q[$];

    basic_search_scheduler u_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort && !sel),
        .curr_valid(curr_valid), .curr_data(curr_data), .curr_ready(a_ready),
        .current_64pixels(a_px), .ref_begin_prepare(a_ref), .pe_begin_prepare(a_pe),
        .search_column_count(col_in), .search_row_count(row_in),
        .sad_valid(a_sv), .sad_col(a_col), .sad_row(a_row), .busy(a_busy), .done(a_done)
    );

    basic_search_scheduler #(
        .SEARCH_COLS(2), .SEARCH_ROWS(1), .SAD_LAT(1), .REF_PRELOAD(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort && sel),
        .curr_valid(curr_valid), .curr_data(curr_data), .curr_ready(b_ready),
        .current_64pixels(b_px), .ref_begin_prepare(b_ref), .pe_begin_prepare(b_pe),
        .search_column_count(col_in), .search_row_count(row_in),
        .sad_valid(b_sv), .sad_col(b_col), .sad_row(b_row), .busy(b_busy), .done(b_done)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_ref   = sel ? b_ref   : a_ref;
    assign m_pe    = sel ? b_pe    : a_pe;
    assign m_sv    = sel ? b_sv    : a_sv;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_px    = sel ? b_px    : a_px;
    assign m_col   = sel ? b_col   : a_col;
    assign m_row   = sel ? b_row   : a_row;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic prune(input int a);
        for (int i = sad_q.size() - 1; i >= 0; i--) if (sad_q[i].cyc > a) sad_q.delete(i);
        for (int i = evt_q.size() - 1; i >= 0; i--) if (evt_q[i].cyc > a) evt_q.delete(i);
    endtask

    task automatic evt_mon(input int kind);
        evt_t e;
        if (evt_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = evt_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_ref && m_pe) chk("ref_pe_overlap", 1, 0);
            if (curr_valid && m_ready) evt_mon(0);
            if (m_ref) evt_mon(1);
            if (m_pe) evt_mon(2);
            if (m_done) evt_mon(3);
            if (m_sv) begin
                if (sad_q.size() == 0) begin
                    chk("unexpected_sad_valid", 1, 0);
                end else begin
                    sad_t s;
                    s = sad_q.pop_front();
                    chk("sad_cycle", cyc, s.cyc);
                    chk("sad_col", m_col, s.col);
                    chk("sad_row", m_row, s.row);
                end
            end
        end
    end

    // mode 0: full search; 1: abort in PRELOAD; 2: abort after k positions;
    // 3: start pulse at k/2 then async reset after k positions.
    task automatic do_block(input int vprob, input int mode, input int k);
        int got = 0;
        int n = 0;
        logic [511:0] last_px = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (got < BEATS) begin
            curr_valid = ($urandom_range(99) < vprob);
            curr_data  = rand512();
            if (curr_valid) begin
                evt_q.push_back(evt_t'{cyc, 0});
                got++;
                last_px = curr_data;
                if (got == BEATS) begin
                    evt_q.push_back(evt_t'{cyc + 1, 1});
                    evt_q.push_back(evt_t'{cyc + 1 + pre, 2});
                end
            end
            tick();
        end
        curr_valid = 1'($urandom_range(1));
        chk("ready_drop_after_load", m_ready, 0);
        chk("pixels_last_beat", (m_px == last_px) ? 1 : 0, 1);
        if (mode == 1) begin
            tick();
            abort = 1'b1;
            prune(cyc);
            tick();
            abort = 1'b0;
            chk("busy_after_preload_abort", m_busy, 0);
            repeat (pre + 2) tick();
            return;
        end
        repeat (pre) tick();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if ((mode == 2 || mode == 3) && n == k) begin
                    start = 1'b0;
                    if (mode == 2) begin
                        abort = 1'b1;
                        prune(cyc);
                        tick();
                        abort = 1'b0;
                        chk("busy_after_search_abort", m_busy, 0);
                        chk("sad_valid_after_abort", m_sv, 0);
                        repeat (lat + 2) tick();
                    end else begin
                        #1 rst_n = 1'b0;
                        #1;
                        chk("rst_busy", m_busy, 0);
                        chk("rst_sad_valid", m_sv, 0);
                        chk("rst_sad_tag", {m_col, m_row}, 0);
                        chk("rst_ready", m_ready, 0);
                        chk("rst_pulses", {m_ref, m_pe, m_done}, 0);
                        chk("rst_pixels", (m_px == '0) ? 1 : 0, 1);
                        sad_q.delete();
                        evt_q.delete();
                        @(posedge clk);
                        #1 rst_n = 1'b1;
                        tick();
                    end
                    return;
                end
                start  = (mode == 3 && n == k / 2);
                col_in = 5'(c);
                row_in = 7'(r);
                sad_q.push_back(sad_t'{cyc + lat, 5'(c), 7'(r)});
                if (r == rows - 1 && c == cols - 1) evt_q.push_back(evt_t'{cyc + lat + 1, 3});
                n++;
                tick();
            end
        end
        start = 1'b0;
        col_in = 5'($urandom_range(31));
        repeat (lat) tick();
        chk("busy_in_done_cycle", m_busy, 1);
        tick();
        chk("busy_after_done", m_busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", a_busy, 0);
        chk("reset_ready", a_ready, 0);
        chk("reset_sad_valid", a_sv, 0);
        chk("reset_pulses", {a_ref, a_pe, a_done}, 0);
        chk("reset_pixels", (a_px == '0) ? 1 : 0, 1);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", a_busy, 0);
        tick();
        do_block(100, 0, 0);
        do_block(50, 1, 0);
        do_block(70, 2, 100);
        do_block(100, 3, 300);
        do_block(60, 0, 0);
        sel = 1'b1;
        lat = 1;
        pre = 1;
        cols = 2;
        rows = 1;
        tick();
        do_block(100, 0, 0);
        repeat (4) tick();
        chk("sad_left_unseen", sad_q.size(), 0);
        chk("events_left_unseen", evt_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
